mux_regfile_nr1w: RTL

//  Parametrised register file with 1 write port and NRD read ports.

---
 rtl/mux_regfile_nr1w.sv | 81 ++++++++
 1 files changed

// File: rtl/mux_regfile_nr1w.sv
// Register file with one synchronous write port and NRD independent read muxes.
// Optional hardwired zero entry, write-to-read bypass and registered read data.
module mux_regfile_nr1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_OUT  = 0
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         We,
    input  logic [$clog2(DEPTH)-1:0]     Waddr,
    input  logic [WIDTH-1:0]             Din,
    input  logic [NRD*$clog2(DEPTH)-1:0] Raddr,
    output logic [NRD*WIDTH-1:0]         Dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic             w_wr_ok;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Out-of-range and zero-entry writes are squashed here so bypass sees the same decision.
    assign w_wr_ok = We && ({1'b0, Waddr} < DEPTH_V) && !(ZERO_REG != 0 && Waddr == '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_wr_ok && Waddr == AW'(i)) begin
                    r_mem[i] <= Din;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0]    w_ra;
        logic [WIDTH-1:0] w_rd;

        assign w_ra = Raddr[k*AW +: AW];

        // Unmatched addresses (>= DEPTH) fall through to the zero default.
        always_comb begin
            w_rd = '0;
            if (ZERO_REG != 0 && w_ra == '0) begin
                w_rd = '0;
            end else if (BYPASS != 0 && w_wr_ok && w_ra == Waddr) begin
                w_rd = Din;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (w_ra == AW'(i)) begin
                        w_rd = r_mem[i];
                    end
                end
            end
        end

        if (REG_OUT != 0) begin : g_reg
            logic [WIDTH-1:0] r_dout;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_dout <= '0;
                end else begin
                    r_dout <= w_rd;
                end
            end

            assign Dout[k*WIDTH +: WIDTH] = r_dout;
        end else begin : g_comb
            assign Dout[k*WIDTH +: WIDTH] = w_rd;
        end
    end

endmodule
